// File: rtl/to_udp_multi_src_adapter_if.sv
// to_udp_multi_src_adapter_if
// Bundles the handshake signals between the application sources, the
// multi-source UDP adapter and the NoC local port.
//
// Signals (N = N_SRC):
//   src_meta_val/rdy    [N]         metadata handshake per source
//   src_meta_info       [N][112]    {src_ip, dst_ip, src_port, dst_port, data_length}
//   src_meta_dst_x/y    [N][8]      destination tile coordinates
//   src_meta_dst_fbits  [N][4]      destination fbits
//   src_data_val/rdy    [N]         data flit handshake per source
//   src_data            [N][W]      data flit per source
//   noc_out_val/rdy                 output flit handshake toward the NoC
//   noc_out_data        [W]         output flit
//
// Modports:
//   master - the adapter (drives the ready signals and the NoC output)
//   slave  - the environment (sources plus NoC router)
interface to_udp_multi_src_adapter_if #(
  parameter int NOC_DATA_W = 512,
  parameter int N_SRC      = 4
);
  localparam int XY_WIDTH        = 8;
  localparam int NOC_FBITS_WIDTH = 4;
  localparam int UDP_INFO_W      = 112;

  logic [N_SRC-1:0]                      src_meta_val;
  logic [N_SRC-1:0][UDP_INFO_W-1:0]      src_meta_info;
  logic [N_SRC-1:0][XY_WIDTH-1:0]        src_meta_dst_x;
  logic [N_SRC-1:0][XY_WIDTH-1:0]        src_meta_dst_y;
  logic [N_SRC-1:0][NOC_FBITS_WIDTH-1:0] src_meta_dst_fbits;
  logic [N_SRC-1:0]                      src_meta_rdy;
  logic [N_SRC-1:0]                      src_data_val;
  logic [N_SRC-1:0][NOC_DATA_W-1:0]      src_data;
  logic [N_SRC-1:0]                      src_data_rdy;
  logic                                  noc_out_val;
  logic [NOC_DATA_W-1:0]                 noc_out_data;
  logic                                  noc_out_rdy;

  modport master (
    input  src_meta_val, src_meta_info, src_meta_dst_x, src_meta_dst_y,
           src_meta_dst_fbits, src_data_val, src_data, noc_out_rdy,
    output src_meta_rdy, src_data_rdy, noc_out_val, noc_out_data
  );

  modport slave (
    output src_meta_val, src_meta_info, src_meta_dst_x, src_meta_dst_y,
           src_meta_dst_fbits, src_data_val, src_data, noc_out_rdy,
    input  src_meta_rdy, src_data_rdy, noc_out_val, noc_out_data
  );
endinterface

// File: rtl/to_udp_multi_src_adapter.sv
// to_udp_multi_src_adapter
// Merges N_SRC application sources onto one NoC output toward the UDP TX
// engine. Each message: round-robin grant among sources with pending
// metadata, then a header flit, one UDP TX metadata flit and the granted
// source's data flits.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          to_udp_multi_src_adapter_if.master (all handshakes)
//   busy         high whenever the controller is not IDLE
//   stat_msgs    [N_SRC][32] messages completed per source (stats build only)
//   stat_flits   [N_SRC][32] flits sent per source (stats build only)
//
// Optional feature macro: TO_UDP_ADAPTER_STATS_EN adds the stat_* outputs.
//
// Flit layouts:
//   header   : top 64 bits = {dst_x[8], dst_y[8], dst_fbits[4], msg_len[14],
//              msg_type[8], src_x[8], src_y[8], src_fbits[4],
//              metadata_flits[2]}, rest zero
//   metadata : low 112 bits = {src_ip, dst_ip, src_port, dst_port,
//              data_length}, rest zero (needs NOC_DATA_W >= 128)
module to_udp_multi_src_adapter #(
  parameter int NOC_DATA_W = 512,
  parameter int N_SRC      = 4,
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0
) (
  input  logic clk,
  input  logic rst_n,
  to_udp_multi_src_adapter_if.master bus,
  output logic busy
`ifdef TO_UDP_ADAPTER_STATS_EN
  ,
  output logic [N_SRC-1:0][31:0] stat_msgs,
  output logic [N_SRC-1:0][31:0] stat_flits
`endif
);
  localparam int XY_WIDTH         = 8;
  localparam int UDP_INFO_W       = 112;
  localparam int MSG_LENGTH_WIDTH = 14;
  localparam int HDR_W            = 64;
  localparam int IDX_W            = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int BYTES_PER_FLIT   = NOC_DATA_W / 8;
  localparam int FLIT_SHIFT       = $clog2(BYTES_PER_FLIT);
  localparam logic [3:0] PKT_IF_FBITS   = 4'd2;
  localparam logic [7:0] UDP_TX_SEGMENT = 8'h10;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_info_t;

  typedef struct packed {
    logic [XY_WIDTH-1:0]         dst_x;
    logic [XY_WIDTH-1:0]         dst_y;
    logic [3:0]                  dst_fbits;
    logic [MSG_LENGTH_WIDTH-1:0] msg_len;
    logic [7:0]                  msg_type;
    logic [7:0]                  src_x;
    logic [7:0]                  src_y;
    logic [3:0]                  src_fbits;
    logic [1:0]                  metadata_flits;
  } udp_noc_hdr_t;

  typedef enum logic [1:0] {IDLE, HDR, META, DATA} state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]            grant_q, grant_d;
  udp_info_t                   info_q, info_d;
  logic [XY_WIDTH-1:0]         dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [3:0]                  dst_fbits_q, dst_fbits_d;
  logic [MSG_LENGTH_WIDTH-1:0] total_q, total_d, flit_cnt_q, flit_cnt_d;
`ifdef TO_UDP_ADAPTER_STATS_EN
  logic [N_SRC-1:0][31:0]      stat_msgs_q, stat_msgs_d, stat_flits_q, stat_flits_d;
`endif

  logic                        arb_found;
  logic [IDX_W-1:0]            arb_idx, cand_idx;
  int                          cand;
  udp_info_t                   arb_info;
  logic [MSG_LENGTH_WIDTH-1:0] num_data;
  logic                        xfer, last_xfer;
  udp_noc_hdr_t                hdr;

  // ceil(data_length / bytes-per-flit) as a shift plus a remainder test
  function automatic logic [MSG_LENGTH_WIDTH-1:0] calc_num_data(input logic [15:0] dl);
    return MSG_LENGTH_WIDTH'(dl >> FLIT_SHIFT) +
           MSG_LENGTH_WIDTH'(|(dl & 16'(BYTES_PER_FLIT - 1)));
  endfunction

  // Round-robin scan starting at rr_ptr, wrapping modulo N_SRC
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= N_SRC) cand = cand - N_SRC;
      cand_idx = IDX_W'(cand);
      if (!arb_found && bus.src_meta_val[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
    arb_info = bus.src_meta_info[arb_idx];
  end

  assign num_data  = total_q - 1'b1;
  assign xfer      = bus.noc_out_val && bus.noc_out_rdy;
  assign last_xfer = xfer && (((state_q == META) && (total_q == MSG_LENGTH_WIDTH'(1))) ||
                              ((state_q == DATA) && (flit_cnt_q == num_data - 1'b1)));

  // State and datapath registers; reset abandons any message in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      info_q       <= '0;
      dst_x_q      <= '0;
      dst_y_q      <= '0;
      dst_fbits_q  <= '0;
      total_q      <= '0;
      flit_cnt_q   <= '0;
`ifdef TO_UDP_ADAPTER_STATS_EN
      stat_msgs_q  <= '0;
      stat_flits_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      info_q       <= info_d;
      dst_x_q      <= dst_x_d;
      dst_y_q      <= dst_y_d;
      dst_fbits_q  <= dst_fbits_d;
      total_q      <= total_d;
      flit_cnt_q   <= flit_cnt_d;
`ifdef TO_UDP_ADAPTER_STATS_EN
      stat_msgs_q  <= stat_msgs_d;
      stat_flits_q <= stat_flits_d;
`endif
    end
  end

  // Next-state: grant and latch in IDLE, advance on each accepted flit
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    info_d      = info_q;
    dst_x_d     = dst_x_q;
    dst_y_d     = dst_y_q;
    dst_fbits_d = dst_fbits_q;
    total_d     = total_q;
    flit_cnt_d  = flit_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d     = HDR;
          grant_d     = arb_idx;
          info_d      = arb_info;
          dst_x_d     = bus.src_meta_dst_x[arb_idx];
          dst_y_d     = bus.src_meta_dst_y[arb_idx];
          dst_fbits_d = bus.src_meta_dst_fbits[arb_idx];
          total_d     = calc_num_data(arb_info.data_length) + 1'b1;
          flit_cnt_d  = '0;
          rr_ptr_d    = (arb_idx == IDX_W'(N_SRC - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      HDR:  if (xfer) state_d = META;
      META: if (xfer) state_d = last_xfer ? IDLE : DATA;
      DATA: begin
        if (xfer) begin
          flit_cnt_d = flit_cnt_q + 1'b1;
          if (last_xfer) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TO_UDP_ADAPTER_STATS_EN
  // Per-source counters charged to the source holding the grant
  always_comb begin
    stat_msgs_d  = stat_msgs_q;
    stat_flits_d = stat_flits_q;
    if (xfer && (state_q != IDLE)) stat_flits_d[grant_q] = stat_flits_q[grant_q] + 32'd1;
    if (last_xfer) stat_msgs_d[grant_q] = stat_msgs_q[grant_q] + 32'd1;
  end

  assign stat_msgs  = stat_msgs_q;
  assign stat_flits = stat_flits_q;
`endif

  // Outputs; header/metadata come only from latched state so they stay
  // stable while the NoC stalls. meta_rdy is gated by rst_n so nothing is
  // accepted while reset is held.
  always_comb begin
    bus.src_meta_rdy   = '0;
    bus.src_data_rdy   = '0;
    bus.noc_out_val    = 1'b0;
    bus.noc_out_data   = '0;
    busy               = (state_q != IDLE);
    hdr                = '0;
    hdr.dst_x          = dst_x_q;
    hdr.dst_y          = dst_y_q;
    hdr.dst_fbits      = dst_fbits_q;
    hdr.msg_len        = total_q;
    hdr.msg_type       = UDP_TX_SEGMENT;
    hdr.src_x          = 8'(SRC_X);
    hdr.src_y          = 8'(SRC_Y);
    hdr.src_fbits      = PKT_IF_FBITS;
    hdr.metadata_flits = 2'd1;
    case (state_q)
      IDLE: if (rst_n && arb_found) bus.src_meta_rdy[arb_idx] = 1'b1;
      HDR: begin
        bus.noc_out_val                          = 1'b1;
        bus.noc_out_data[NOC_DATA_W-1 -: HDR_W] = hdr;
      end
      META: begin
        bus.noc_out_val                  = 1'b1;
        bus.noc_out_data[UDP_INFO_W-1:0] = info_q;
      end
      DATA: begin
        bus.noc_out_val           = bus.src_data_val[grant_q];
        bus.noc_out_data          = bus.src_data[grant_q];
        bus.src_data_rdy[grant_q] = bus.noc_out_rdy;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_to_udp_multi_src_adapter.sv
// tb_to_udp_multi_src_adapter
// Directed self-checking bench for to_udp_multi_src_adapter
// (NOC_DATA_W=512, N_SRC=4, SRC_X=3, SRC_Y=5). Source s uses destination
// x=s+1, y=s+10, fbits=s+1. Stats checks are compiled in when
// TO_UDP_ADAPTER_STATS_EN is defined.
module tb_to_udp_multi_src_adapter;
  localparam int NOC_DATA_W = 512;
  localparam int N_SRC      = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_asserts = 0;
  int   n_fail    = 0;
`ifdef TO_UDP_ADAPTER_STATS_EN
  logic [N_SRC-1:0][31:0] stat_msgs, stat_flits;
`endif

  to_udp_multi_src_adapter_if #(.NOC_DATA_W(NOC_DATA_W), .N_SRC(N_SRC)) bus ();

  to_udp_multi_src_adapter #(
    .NOC_DATA_W(NOC_DATA_W), .N_SRC(N_SRC), .SRC_X(3), .SRC_Y(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef TO_UDP_ADAPTER_STATS_EN
    ,
    .stat_msgs  (stat_msgs),
    .stat_flits (stat_flits)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [111:0] make_info(input int s, input logic [15:0] dl);
    return {32'hC0A80001 + 32'(s), 32'h0A000001 + 32'(s), 16'(1000 + s), 16'(2000 + s), dl};
  endfunction

  function automatic logic [511:0] data_pat(input int s, input int k);
    return {64{8'(s * 16 + k + 1)}};
  endfunction

  function automatic logic [511:0] exp_hdr(input int s, input int len);
    logic [511:0] r;
    r = '0;
    r[511:448] = {8'(s + 1), 8'(s + 10), 4'(s + 1), 14'(len), 8'h10, 8'd3, 8'd5, 4'd2, 2'd1};
    return r;
  endfunction

  function automatic logic [511:0] exp_meta(input int s, input logic [15:0] dl);
    logic [511:0] r;
    r = '0;
    r[111:0] = make_info(s, dl);
    return r;
  endfunction

  function automatic logic [3:0] onehot(input int s);
    return 4'(1 << s);
  endfunction

  // One comparison: counts it, and reports tag/observed/expected on failure
  task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int s, input logic [15:0] dl);
    bus.src_meta_val[s]       = 1'b1;
    bus.src_meta_info[s]      = make_info(s, dl);
    bus.src_meta_dst_x[s]     = 8'(s + 1);
    bus.src_meta_dst_y[s]     = 8'(s + 10);
    bus.src_meta_dst_fbits[s] = 4'(s + 1);
  endtask

  // Full message with noc_out_rdy held high, starting from IDLE
  task automatic send_msg(input int s, input logic [15:0] dl, input int exp_len,
                          input int n_data, input bit hold);
    apply_stimulus(s, dl);
    #1;
    check_output("idle_meta_rdy", 512'(bus.src_meta_rdy), 512'(onehot(s)));
    check_output("idle_busy", 512'(busy), 512'(0));
    tick();
    if (!hold) bus.src_meta_val[s] = 1'b0;
    #1;
    check_output("hdr_val", 512'(bus.noc_out_val), 512'(1));
    check_output("hdr_data", bus.noc_out_data, exp_hdr(s, exp_len));
    check_output("hdr_busy", 512'(busy), 512'(1));
    check_output("hdr_data_rdy", 512'(bus.src_data_rdy), 512'(0));
    tick();
    #1;
    check_output("meta_val", 512'(bus.noc_out_val), 512'(1));
    check_output("meta_data", bus.noc_out_data, exp_meta(s, dl));
    check_output("meta_data_rdy", 512'(bus.src_data_rdy), 512'(0));
    for (int k = 0; k < n_data; k++) begin
      tick();
      bus.src_data_val[s] = 1'b1;
      bus.src_data[s]     = data_pat(s, k);
      #1;
      check_output("data_val", 512'(bus.noc_out_val), 512'(1));
      check_output("data_flit", bus.noc_out_data, data_pat(s, k));
      check_output("data_rdy", 512'(bus.src_data_rdy), 512'(onehot(s)));
    end
    tick();
    bus.src_data_val[s] = 1'b0;
    #1;
    check_output("end_busy", 512'(busy), 512'(0));
    check_output("end_val", 512'(bus.noc_out_val), 512'(0));
  endtask

  initial begin
    bus.src_meta_val       = '0;
    bus.src_meta_info      = '0;
    bus.src_meta_dst_x     = '0;
    bus.src_meta_dst_y     = '0;
    bus.src_meta_dst_fbits = '0;
    bus.src_data_val       = '0;
    bus.src_data           = '0;
    bus.noc_out_rdy        = 1'b0;

    // Reset state, with a request pending that must not be accepted
    apply_stimulus(0, 16'd100);
    #2;
    check_output("rst_val", 512'(bus.noc_out_val), 512'(0));
    check_output("rst_busy", 512'(busy), 512'(0));
    check_output("rst_meta_rdy", 512'(bus.src_meta_rdy), 512'(0));
    check_output("rst_data_rdy", 512'(bus.src_data_rdy), 512'(0));
    bus.src_meta_val = '0;
    bus.noc_out_rdy  = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    $display("[TB] single source, data_length 100 / 64 / 0");
    send_msg(0, 16'd100, 3, 2, 1'b0);
    send_msg(1, 16'd64, 2, 1, 1'b0);
    bus.src_data_val[2] = 1'b1;
    bus.src_data[2]     = data_pat(2, 0);
    send_msg(2, 16'd0, 1, 0, 1'b0);

    $display("[TB] noc_out_rdy toggling, source 3");
    tick();
    apply_stimulus(3, 16'd100);
    #1;
    check_output("tg_meta_rdy", 512'(bus.src_meta_rdy), 512'(onehot(3)));
    tick();
    bus.src_meta_val[3] = 1'b0;
    bus.noc_out_rdy     = 1'b0;
    #1;
    check_output("tg_hdr_stall", bus.noc_out_data, exp_hdr(3, 3));
    tick();
    bus.noc_out_rdy = 1'b1;
    #1;
    check_output("tg_hdr_hold", bus.noc_out_data, exp_hdr(3, 3));
    tick();
    bus.noc_out_rdy     = 1'b0;
    bus.src_data_val[3] = 1'b1;
    bus.src_data[3]     = data_pat(3, 0);
    #1;
    check_output("tg_meta_stall", bus.noc_out_data, exp_meta(3, 16'd100));
    check_output("tg_meta_data_rdy", 512'(bus.src_data_rdy), 512'(0));
    tick();
    bus.noc_out_rdy = 1'b1;
    #1;
    check_output("tg_meta_hold", bus.noc_out_data, exp_meta(3, 16'd100));
    tick();
    bus.noc_out_rdy = 1'b0;
    #1;
    check_output("tg_d0_stall", bus.noc_out_data, data_pat(3, 0));
    check_output("tg_d0_stall_rdy", 512'(bus.src_data_rdy), 512'(0));
    tick();
    bus.noc_out_rdy = 1'b1;
    #1;
    check_output("tg_d0_go", bus.noc_out_data, data_pat(3, 0));
    check_output("tg_d0_go_rdy", 512'(bus.src_data_rdy), 512'(onehot(3)));
    tick();
    bus.noc_out_rdy = 1'b0;
    bus.src_data[3] = data_pat(3, 1);
    #1;
    check_output("tg_d1_stall", bus.noc_out_data, data_pat(3, 1));
    check_output("tg_d1_stall_rdy", 512'(bus.src_data_rdy), 512'(0));
    check_output("tg_d1_busy", 512'(busy), 512'(1));
    tick();
    bus.noc_out_rdy = 1'b1;
    #1;
    check_output("tg_d1_go", bus.noc_out_data, data_pat(3, 1));
    check_output("tg_d1_go_rdy", 512'(bus.src_data_rdy), 512'(onehot(3)));
    tick();
    bus.src_data_val[3] = 1'b0;
    #1;
    check_output("tg_end_busy", 512'(busy), 512'(0));

    $display("[TB] reset in the middle of DATA");
    apply_stimulus(1, 16'd150);
    #1;
    check_output("rs_meta_rdy", 512'(bus.src_meta_rdy), 512'(onehot(1)));
    tick();
    bus.src_meta_val[1] = 1'b0;
    #1;
    check_output("rs_hdr", bus.noc_out_data, exp_hdr(1, 4));
    tick();
    bus.src_data_val[1] = 1'b1;
    bus.src_data[1]     = data_pat(1, 0);
    #1;
    check_output("rs_meta", bus.noc_out_data, exp_meta(1, 16'd150));
    tick();
    #1;
    check_output("rs_d0", bus.noc_out_data, data_pat(1, 0));
    tick();
    bus.src_data[1] = data_pat(1, 1);
    #1;
    check_output("rs_d1_val", 512'(bus.noc_out_val), 512'(1));
    rst_n = 1'b0;
    for (int s = 0; s < N_SRC; s++) apply_stimulus(s, 16'd1);
    #1;
    check_output("rs_val_drop", 512'(bus.noc_out_val), 512'(0));
    check_output("rs_data_rdy_drop", 512'(bus.src_data_rdy), 512'(0));
    check_output("rs_meta_rdy_drop", 512'(bus.src_meta_rdy), 512'(0));
    check_output("rs_busy_drop", 512'(busy), 512'(0));
    bus.src_data_val = '0;
    tick();
    tick();
    rst_n = 1'b1;

    $display("[TB] all sources requesting, expect rotation 0,1,2,3,0");
    for (int m = 0; m < 5; m++) send_msg(m % N_SRC, 16'd1, 2, 1, 1'b1);
    bus.src_meta_val = '0;

`ifdef TO_UDP_ADAPTER_STATS_EN
    $display("[TB] stats, source 2 with data_length 0 / 64 / 200");
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_output("st_rst_msgs", 512'(stat_msgs[0]), 512'(0));
    send_msg(2, 16'd0, 1, 0, 1'b0);
    send_msg(2, 16'd64, 2, 1, 1'b0);
    send_msg(2, 16'd200, 5, 4, 1'b0);
    check_output("st_msgs2", 512'(stat_msgs[2]), 512'(3));
    check_output("st_flits2", 512'(stat_flits[2]), 512'(11));
    check_output("st_flits0", 512'(stat_flits[0]), 512'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
